// File: rtl/galetron_pkg.sv
// Shared Galetron definitions: sequencer state encoding, next-PC select codes
// and the opcode map used by the control decoder.
package galetron_pkg;

    localparam int unsigned GaletronAddrWidth = 10;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StWaitIn = 2'd1,
        StWaitHd = 2'd2,
        StHalted = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        PcHold   = 2'd0,
        PcIncr   = 2'd1,
        PcTarget = 2'd2
    } pc_sel_e;

    localparam int unsigned OpcodeWidth = 6;

    localparam logic [OpcodeWidth-1:0] OpNop     = 6'h00;
    localparam logic [OpcodeWidth-1:0] OpAdd     = 6'h01;
    localparam logic [OpcodeWidth-1:0] OpSub     = 6'h02;
    localparam logic [OpcodeWidth-1:0] OpAnd     = 6'h03;
    localparam logic [OpcodeWidth-1:0] OpOr      = 6'h04;
    localparam logic [OpcodeWidth-1:0] OpLoad    = 6'h10;
    localparam logic [OpcodeWidth-1:0] OpStore   = 6'h11;
    localparam logic [OpcodeWidth-1:0] OpHdStore = 6'h12;
    localparam logic [OpcodeWidth-1:0] OpIn      = 6'h20;
    localparam logic [OpcodeWidth-1:0] OpOut     = 6'h21;
    localparam logic [OpcodeWidth-1:0] OpJmp     = 6'h30;
    localparam logic [OpcodeWidth-1:0] OpBz      = 6'h31;
    localparam logic [OpcodeWidth-1:0] OpBn      = 6'h32;
    localparam logic [OpcodeWidth-1:0] OpHlt     = 6'h3f;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: hold, sequential increment (wraps modulo
// 2^ADDR_WIDTH) or unmodified branch/jump target.
module pc_next_logic
    import galetron_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = GaletronAddrWidth
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] target,
    input  pc_sel_e               sel,
    output logic [ADDR_WIDTH-1:0] pc_next
);

    always_comb begin
        pc_next = pc;
        case (sel)
            PcIncr:   pc_next = pc + ADDR_WIDTH'(1);
            PcTarget: pc_next = target;
            default:  pc_next = pc;
        endcase
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Galetron program-flow sequencer: PC, registered ALU flags, branch resolution
// and wait states for user input (IN), disk stores (HD) and halt.
module instruction_sequencer
    import galetron_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH = GaletronAddrWidth,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned          HD_TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  jump,
    input  logic                  bzero,
    input  logic                  bnegative,
    input  logic                  HLT,
    input  logic                  in_req,
    input  logic                  flag_write_hd,
    input  logic                  flag_update,
    input  logic [ADDR_WIDTH-1:0] target_addr,
    input  logic                  alu_zero,
    input  logic                  alu_negative,
    input  logic                  in_valid,
    input  logic                  hd_busy,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  commit,
    output logic                  stall,
    output logic                  in_ack,
    output logic                  hd_start,
    output logic                  hd_error,
    output logic                  halted,
    output logic                  zero_flag,
    output logic                  negative_flag
);

    localparam int unsigned CntWidth = $clog2(HD_TIMEOUT + 1);

    seq_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    pc_sel_e               pc_sel;
    logic [CntWidth-1:0]   hd_cnt_q, hd_cnt_d, hd_cnt_inc;
    logic                  hd_err_q, hd_err_d;
    logic                  zero_q, neg_q;
    logic                  hd_expired;
    logic                  branch_taken;
    logic                  commit_raw, stall_raw, in_ack_raw, hd_start_raw;

    // Branches look only at the registered flags, never the same-cycle ALU.
    assign branch_taken = (bzero & zero_q) | (bnegative & neg_q);
    assign hd_cnt_inc   = hd_cnt_q + CntWidth'(1);
    assign hd_expired   = (hd_cnt_inc == CntWidth'(HD_TIMEOUT));

    pc_next_logic #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_pc_next (
        .pc      (pc_q),
        .target  (target_addr),
        .sel     (pc_sel),
        .pc_next (pc_d)
    );

    always_comb begin
        state_d      = state_q;
        pc_sel       = PcHold;
        hd_cnt_d     = hd_cnt_q;
        hd_err_d     = hd_err_q;
        commit_raw   = 1'b0;
        stall_raw    = 1'b0;
        in_ack_raw   = 1'b0;
        hd_start_raw = 1'b0;

        case (state_q)
            StRun: begin
                hd_cnt_d = '0;
                if (HLT) begin
                    state_d = StHalted;
                end else if (in_req) begin
                    if (in_valid) begin
                        in_ack_raw = 1'b1;
                        commit_raw = 1'b1;
                        pc_sel     = PcIncr;
                    end else begin
                        stall_raw = 1'b1;
                        state_d   = StWaitIn;
                    end
                end else if (flag_write_hd) begin
                    // A busy disk holds the store in RUN; hd_start fires only once idle.
                    if (hd_busy) begin
                        stall_raw = 1'b1;
                    end else begin
                        hd_start_raw = 1'b1;
                        commit_raw   = 1'b1;
                        state_d      = StWaitHd;
                    end
                end else if (jump) begin
                    commit_raw = 1'b1;
                    pc_sel     = PcTarget;
                end else if (bzero || bnegative) begin
                    commit_raw = 1'b1;
                    pc_sel     = branch_taken ? PcTarget : PcIncr;
                end else begin
                    commit_raw = 1'b1;
                    pc_sel     = PcIncr;
                end
            end

            StWaitIn: begin
                if (in_valid) begin
                    in_ack_raw = 1'b1;
                    commit_raw = 1'b1;
                    pc_sel     = PcIncr;
                    state_d    = StRun;
                end else begin
                    stall_raw = 1'b1;
                end
            end

            StWaitHd: begin
                stall_raw = 1'b1;
                hd_cnt_d  = hd_cnt_inc;
                if (!hd_busy || hd_expired) begin
                    pc_sel   = PcIncr;
                    state_d  = StRun;
                    hd_cnt_d = '0;
                    if (hd_busy) begin
                        hd_err_d = 1'b1;
                    end
                end
            end

            StHalted: begin
                stall_raw = 1'b1;
            end

            default: begin
                state_d = StRun;
            end
        endcase
    end

    // Handshake pulses and write enables are suppressed while reset is held.
    assign commit   = commit_raw & ~reset;
    assign stall    = stall_raw & ~reset;
    assign in_ack   = in_ack_raw & ~reset;
    assign hd_start = hd_start_raw & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StRun;
            pc_q     <= RESET_PC;
            hd_cnt_q <= '0;
            hd_err_q <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            hd_cnt_q <= hd_cnt_d;
            hd_err_q <= hd_err_d;
            if (commit_raw && flag_update) begin
                zero_q <= alu_zero;
                neg_q  <= alu_negative;
            end
        end
    end

    assign pc            = pc_q;
    assign hd_error      = hd_err_q;
    assign halted        = (state_q == StHalted);
    assign zero_flag     = zero_q;
    assign negative_flag = neg_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: directed scenarios followed by
// randomized traffic, all compared against a behavioural program-flow model.
module tb_instruction_sequencer;

    localparam int AW    = 10;
    localparam int HD_TO = 15;
    localparam int PC_MOD = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic          jump, bzero, bnegative, HLT, in_req, flag_write_hd, flag_update;
    logic [AW-1:0] target_addr;
    logic          alu_zero, alu_negative, in_valid, hd_busy;
    logic [AW-1:0] pc;
    logic          commit, stall, in_ack, hd_start, hd_error, halted;
    logic          zero_flag, negative_flag;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Behavioural model of the program-flow contract.
    int m_pc        = 0;
    bit m_zero      = 0;
    bit m_neg       = 0;
    bit m_err       = 0;
    bit m_parked    = 0;
    bit m_wait_in   = 0;
    bit m_in_hd     = 0;
    int m_hd_cycles = 0;

    instruction_sequencer #(
        .ADDR_WIDTH (AW),
        .RESET_PC   ('0),
        .HD_TIMEOUT (HD_TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .jump          (jump),
        .bzero         (bzero),
        .bnegative     (bnegative),
        .HLT           (HLT),
        .in_req        (in_req),
        .flag_write_hd (flag_write_hd),
        .flag_update   (flag_update),
        .target_addr   (target_addr),
        .alu_zero      (alu_zero),
        .alu_negative  (alu_negative),
        .in_valid      (in_valid),
        .hd_busy       (hd_busy),
        .pc            (pc),
        .commit        (commit),
        .stall         (stall),
        .in_ack        (in_ack),
        .hd_start      (hd_start),
        .hd_error      (hd_error),
        .halted        (halted),
        .zero_flag     (zero_flag),
        .negative_flag (negative_flag)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        jump = 0; bzero = 0; bnegative = 0; HLT = 0; in_req = 0;
        flag_write_hd = 0; flag_update = 0; target_addr = '0;
        alu_zero = 0; alu_negative = 0; in_valid = 0; hd_busy = 0;
    endtask

    // One clock: compare registered state and combinational outputs against the
    // model, then advance the model by the rules for the current inputs.
    task automatic tick();
        bit e_commit, e_stall, e_ack, e_start, take;
        int n_pc;
        @(negedge clock);
        check("pc", {22'b0, pc}, m_pc);
        check("zero_flag", {31'b0, zero_flag}, {31'b0, m_zero});
        check("negative_flag", {31'b0, negative_flag}, {31'b0, m_neg});
        check("halted", {31'b0, halted}, {31'b0, m_parked});
        check("hd_error", {31'b0, hd_error}, {31'b0, m_err});

        e_commit = 0; e_stall = 0; e_ack = 0; e_start = 0;
        n_pc = m_pc;
        if (reset) begin
            n_pc = 0;
        end else if (m_parked) begin
            e_stall = 1;
        end else if (m_wait_in) begin
            if (in_valid) begin
                e_ack = 1; e_commit = 1; n_pc = m_pc + 1; m_wait_in = 0;
            end else begin
                e_stall = 1;
            end
        end else if (m_in_hd) begin
            e_stall = 1;
            m_hd_cycles++;
            if (!hd_busy || m_hd_cycles == HD_TO) begin
                n_pc = m_pc + 1;
                if (hd_busy) m_err = 1;
                m_in_hd = 0;
                m_hd_cycles = 0;
            end
        end else if (HLT) begin
            m_parked = 1;
        end else if (in_req) begin
            if (in_valid) begin
                e_ack = 1; e_commit = 1; n_pc = m_pc + 1;
            end else begin
                e_stall = 1; m_wait_in = 1;
            end
        end else if (flag_write_hd) begin
            if (hd_busy) begin
                e_stall = 1;
            end else begin
                e_start = 1; e_commit = 1; m_in_hd = 1; m_hd_cycles = 0;
            end
        end else if (jump) begin
            e_commit = 1; n_pc = int'(target_addr);
        end else if (bzero || bnegative) begin
            take = (bzero && m_zero) || (bnegative && m_neg);
            e_commit = 1;
            n_pc = take ? int'(target_addr) : m_pc + 1;
        end else begin
            e_commit = 1; n_pc = m_pc + 1;
        end

        check("commit", {31'b0, commit}, {31'b0, e_commit});
        check("stall", {31'b0, stall}, {31'b0, e_stall});
        check("in_ack", {31'b0, in_ack}, {31'b0, e_ack});
        check("hd_start", {31'b0, hd_start}, {31'b0, e_start});

        if (reset) begin
            m_pc = 0; m_zero = 0; m_neg = 0; m_err = 0;
            m_parked = 0; m_wait_in = 0; m_in_hd = 0; m_hd_cycles = 0;
        end else begin
            if (e_commit && flag_update) begin
                m_zero = alu_zero;
                m_neg  = alu_negative;
            end
            m_pc = n_pc % PC_MOD;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int busy_bias;
        reset = 1;
        set_idle();
        tick();
        tick();
        reset = 0;

        // Straight-line fetch from reset.
        for (int i = 0; i < 5; i++) tick();
        check("seq5", {22'b0, pc}, 32'd5);

        // Flag-driven branches.
        flag_update = 1; alu_zero = 1; tick();
        set_idle(); bzero = 1; target_addr = 10'h100; tick();
        check("bz_taken", {22'b0, pc}, 32'h100);
        set_idle(); flag_update = 1; alu_zero = 0; tick();
        set_idle(); bzero = 1; target_addr = 10'h200; alu_zero = 1; tick();
        check("bz_not_taken", {22'b0, pc}, 32'h102);

        // User input with three wait cycles.
        set_idle(); in_req = 1;
        for (int i = 0; i < 3; i++) tick();
        in_valid = 1; tick();
        check("in_pc", {22'b0, pc}, 32'h103);

        // Disk store that never finishes: timeout path.
        set_idle(); flag_write_hd = 1; tick();
        flag_write_hd = 0; hd_busy = 1;
        for (int i = 0; i < 20; i++) tick();
        check("hd_err_set", {31'b0, hd_error}, 32'd1);
        check("hd_pc", {22'b0, pc}, 32'h109);

        // Sequential wrap at the top of the address space.
        set_idle(); jump = 1; target_addr = 10'h3ff; tick();
        set_idle(); tick();
        check("wrap", {22'b0, pc}, 32'd0);

        // Halt ignores later jumps.
        tick();
        HLT = 1; tick();
        set_idle(); jump = 1; target_addr = 10'h155;
        for (int i = 0; i < 10; i++) tick();
        check("halt_pc", {22'b0, pc}, 32'd1);
        check("halt_flag", {31'b0, halted}, 32'd1);

        // Reset while parked in WAIT_IN.
        set_idle(); reset = 1; tick();
        reset = 0; tick(); tick();
        in_req = 1; tick(); tick();
        in_req = 0; in_valid = 1; reset = 1; tick();
        reset = 0;
        check("rst_pc", {22'b0, pc}, 32'd0);
        check("rst_in_ack", {31'b0, in_ack}, 32'd0);
        check("rst_hd_error", {31'b0, hd_error}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        tick();

        // Randomized traffic.
        busy_bias = 3;
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) busy_bias = int'($urandom_range(0, 10));
            reset         = ($urandom_range(0, 59) == 0) || (m_parked && $urandom_range(0, 3) == 0);
            HLT           = ($urandom_range(0, 49) == 0);
            in_req        = ($urandom_range(0, 5) == 0);
            flag_write_hd = ($urandom_range(0, 5) == 0);
            jump          = ($urandom_range(0, 4) == 0);
            bzero         = ($urandom_range(0, 3) == 0);
            bnegative     = ($urandom_range(0, 3) == 0);
            flag_update   = ($urandom_range(0, 1) == 1);
            alu_zero      = ($urandom_range(0, 1) == 1);
            alu_negative  = ($urandom_range(0, 1) == 1);
            in_valid      = ($urandom_range(0, 2) == 0);
            hd_busy       = (int'($urandom_range(0, 9)) < busy_bias);
            target_addr   = AW'($urandom_range(0, PC_MOD - 1));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
